multicycle_sequencer: RTL and testbench

Phase sequencer and memory handshake engine for the multicycle datapath. Generates the `phase` bit consumed by the instruction decoder as its `pcEnableIn`, and receives back the decoder's `pcEnableOut`, `memWrite` and `IorD`. Runs each instruction in one or two phases and drives a req/ack handshake to a variable-latency unified memory. It stalls the PC and IR until each access completes, and raises a sticky bus error on a memory timeout.

---
 rtl/multicycle_sequencer_if.sv | 25 ++
 rtl/multicycle_sequencer.sv | 128 ++++++++++++
 tb/tb_multicycle_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Decoder/memory handshake bundle for the multicycle phase sequencer.
// The master side is the sequencer; the slave side is the decoder plus memory.
interface multicycle_sequencer_if;
  logic pc_enable_req;
  logic mem_write;
  logic ior_d;
  logic mem_ack;
  logic phase;
  logic mem_req;
  logic mem_we;
  logic pc_commit;
  logic ir_load;
  logic stall;
  logic bus_error;

  modport master (
    input  pc_enable_req, mem_write, ior_d, mem_ack,
    output phase, mem_req, mem_we, pc_commit, ir_load, stall, bus_error
  );

  modport slave (
    output pc_enable_req, mem_write, ior_d, mem_ack,
    input  phase, mem_req, mem_we, pc_commit, ir_load, stall, bus_error
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// One/two-phase instruction sequencer with req/ack memory handshake.
// Define SEQ_TIMEOUT_EN to compile in the wait counter, ERR state and sticky bus_error.
module multicycle_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  localparam int unsigned CNT_W = 8;

  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_max_wait_check
    $error("multicycle_sequencer: MAX_WAIT must be in 1..255");
  end

`ifdef SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {
    P1  = 2'd0,
    P2  = 2'd1,
    ERR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    P1  = 2'd0,
    P2  = 2'd1
  } state_t;
`endif

  state_t state;
  state_t state_nxt;
  logic   in_access;
  logic   commit;
  logic   req_c;
  logic   commit_c;
  logic   stall_c;
  logic   we_c;
  logic   phase_c;
  logic   bus_error_c;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  // Consecutive no-ack cycles within the current access
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= P1;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, access qualification and Mealy outputs
  always_comb begin
    state_nxt   = state;
    in_access   = 1'b0;
    commit      = 1'b0;
    bus_error_c = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wait_cnt_nxt = '0;
`endif

    case (state)
      P1: begin
        in_access = 1'b1;
        if (bus.mem_ack) begin
          commit = bus.pc_enable_req;
          if (!bus.pc_enable_req) begin
            state_nxt = P2;
          end
        end
      end
      P2: begin
        in_access = 1'b1;
        if (bus.mem_ack) begin
          commit    = 1'b1;
          state_nxt = P1;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      ERR: begin
        state_nxt   = ERR;
        bus_error_c = 1'b1;
      end
`endif
      default: state_nxt = P1;
    endcase

`ifdef SEQ_TIMEOUT_EN
    // An ack landing on the limit cycle still wins over the timeout
    if (in_access && !bus.mem_ack && (wait_cnt == WAIT_LIMIT)) begin
      state_nxt = ERR;
    end
    if (in_access && !bus.mem_ack && (state_nxt == state)) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
`endif

    // Reset masks everything but phase, which idles high
    req_c       = in_access & ~reset;
    phase_c     = reset | (state == P1);
    commit_c    = commit & ~reset;
    stall_c     = req_c & ~bus.mem_ack;
    we_c        = req_c & bus.mem_write & ~bus.ior_d;
    bus_error_c = bus_error_c & ~reset;
  end

  assign bus.phase     = phase_c;
  assign bus.mem_req   = req_c;
  assign bus.mem_we    = we_c;
  assign bus.pc_commit = commit_c;
  assign bus.ir_load   = commit_c;
  assign bus.stall     = stall_c;
  assign bus.bus_error = bus_error_c;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MAX_WAIT=4).
module tb_multicycle_sequencer;

  logic clk;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector order: {phase, mem_req, mem_we, pc_commit, ir_load, stall, bus_error}
  task automatic cyc(input string tag, input logic rst, input logic pe,
                     input logic mw, input logic iord, input logic ack,
                     input logic [6:0] exp);
    logic [6:0] obs;
    @(negedge clk);
    reset             = rst;
    bus.pc_enable_req = pe;
    bus.mem_write     = mw;
    bus.ior_d         = iord;
    bus.mem_ack       = ack;
    #1;
    obs = {bus.phase, bus.mem_req, bus.mem_we, bus.pc_commit,
           bus.ir_load, bus.stall, bus.bus_error};
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %07b expected %07b", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset  = 1'b1;
    bus.pc_enable_req = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ior_d         = 1'b0;
    bus.mem_ack       = 1'b0;

    // Reset: only phase high, ack ignored
    cyc("rst0",       1, 0, 0, 0, 0, 7'b1000000);
    cyc("rst_ack",    1, 1, 1, 0, 1, 7'b1000000);

    // Single-phase instructions, zero-wait memory
    cyc("sp1",        0, 1, 0, 1, 1, 7'b1101100);
    cyc("sp2",        0, 1, 0, 1, 1, 7'b1101100);
    cyc("sp3",        0, 1, 0, 1, 1, 7'b1101100);
    cyc("sp4",        0, 1, 0, 1, 1, 7'b1101100);

    // Two-phase store: write strobe only in phase 2
    cyc("sw_p1",      0, 0, 1, 1, 1, 7'b1100000);
    cyc("sw_p2",      0, 0, 1, 0, 1, 7'b0111100);
    cyc("sw_next",    0, 1, 0, 1, 1, 7'b1101100);

    // Phase-2 ack delayed by 3 cycles, write strobe held stable
    cyc("dly_p1",     0, 0, 1, 1, 1, 7'b1100000);
    cyc("dly_w1",     0, 0, 1, 0, 0, 7'b0110010);
    cyc("dly_w2",     0, 0, 1, 0, 0, 7'b0110010);
    cyc("dly_w3",     0, 0, 1, 0, 0, 7'b0110010);
    cyc("dly_ack",    0, 0, 1, 0, 1, 7'b0111100);
    cyc("dly_next",   0, 1, 0, 1, 1, 7'b1101100);

    // Two-phase load: no write strobe
    cyc("lw_p1",      0, 0, 0, 1, 1, 7'b1100000);
    cyc("lw_p2",      0, 0, 0, 0, 1, 7'b0101100);

    // Ack on the limit cycle completes normally
    cyc("lim_w1",     0, 1, 0, 1, 0, 7'b1100010);
    cyc("lim_w2",     0, 1, 0, 1, 0, 7'b1100010);
    cyc("lim_w3",     0, 1, 0, 1, 0, 7'b1100010);
    cyc("lim_w4",     0, 1, 0, 1, 0, 7'b1100010);
    cyc("lim_ack",    0, 1, 0, 1, 1, 7'b1101100);
    cyc("lim_next",   0, 1, 0, 1, 1, 7'b1101100);

`ifdef SEQ_TIMEOUT_EN
    // Five no-ack cycles time out into the sticky error state
    cyc("to_w1",      0, 1, 0, 1, 0, 7'b1100010);
    cyc("to_w2",      0, 1, 0, 1, 0, 7'b1100010);
    cyc("to_w3",      0, 1, 0, 1, 0, 7'b1100010);
    cyc("to_w4",      0, 1, 0, 1, 0, 7'b1100010);
    cyc("to_w5",      0, 1, 0, 1, 0, 7'b1100010);
    cyc("err0",       0, 1, 0, 1, 0, 7'b0000001);
    cyc("err_ack",    0, 1, 0, 1, 1, 7'b0000001);
    cyc("err_ack2",   0, 1, 0, 1, 1, 7'b0000001);
    cyc("err_rst",    1, 1, 0, 1, 1, 7'b1000000);
    cyc("err_rel",    0, 1, 0, 1, 1, 7'b1101100);
`else
    // Without the timeout the sequencer waits indefinitely
    for (int i = 0; i < 8; i++) begin
      cyc("nto_wait", 0, 1, 0, 1, 0, 7'b1100010);
    end
    cyc("nto_ack",    0, 1, 0, 1, 1, 7'b1101100);
`endif

    // Reset during a phase-2 wait abandons the access
    cyc("rw_p1",      0, 0, 1, 1, 1, 7'b1100000);
    cyc("rw_w1",      0, 0, 1, 0, 0, 7'b0110010);
    cyc("rw_w2",      0, 0, 1, 0, 0, 7'b0110010);
    cyc("rw_rst",     1, 0, 1, 0, 1, 7'b1000000);
    cyc("rw_rel",     0, 1, 0, 1, 1, 7'b1101100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
